ex_operand_stage: RTL and testbench

- Parametrised successor to the execute-stage ALU source-B mux.
- Selects ALU operands A and B with N-source register forwarding, muxing the immediate onto B (ALUSrc) and the PC onto A (ALUSrcA).
- Registers the result into a one-entry ID/EX pipeline slot with a valid/ready handshake, stall and flush.
- Sits between decode and the ALU.

---
 rtl/ex_operand_stage_if.sv | 41 ++++
 rtl/ex_operand_stage.sv | 108 ++++++++++
 tb/tb_ex_operand_stage.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_if.sv
// Decode-to-execute operand bundle: decode inputs, forwarding taps and the
// registered ALU-side outputs of ex_operand_stage.
interface ex_operand_stage_if #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
);
    logic                      valid_in;
    logic                      ready_in;
    logic [XLEN-1:0]           RD1D;
    logic [XLEN-1:0]           RD2D;
    logic [XLEN-1:0]           ImmExtD;
    logic [XLEN-1:0]           PCD;
    logic [REG_AW-1:0]         Rs1D;
    logic [REG_AW-1:0]         Rs2D;
    logic                      ALUSrcD;
    logic                      ALUSrcAD;
    logic [NUM_FWD-1:0]        fwd_we;
    logic [NUM_FWD*REG_AW-1:0] fwd_rd;
    logic [NUM_FWD*XLEN-1:0]   fwd_data;
    logic                      flush;
    logic                      valid_out;
    logic                      ready_out;
    logic [XLEN-1:0]           SrcAE;
    logic [XLEN-1:0]           SrcBE;
    logic [XLEN-1:0]           WriteDataE;

    // Drives decode/forwarding inputs and the ALU-side ready.
    modport master (
        output valid_in, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D,
               ALUSrcD, ALUSrcAD, fwd_we, fwd_rd, fwd_data, flush, ready_out,
        input  ready_in, valid_out, SrcAE, SrcBE, WriteDataE
    );

    // The operand stage itself.
    modport slave (
        input  valid_in, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D,
               ALUSrcD, ALUSrcAD, fwd_we, fwd_rd, fwd_data, flush, ready_out,
        output ready_in, valid_out, SrcAE, SrcBE, WriteDataE
    );
endinterface

// File: rtl/ex_operand_stage.sv
// Execute operand stage: N-source forwarding, PC/immediate muxing and a one-entry
// ID/EX slot with valid/ready, stall and flush. Optional EXE_STALL_CNT_EN adds stall_cnt.
module ex_operand_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int REG_AW  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ex_operand_stage_if.slave    bus
`ifdef EXE_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    logic [REG_AW-1:0]  w_fwd_rd   [NUM_FWD];
    logic [XLEN-1:0]    w_fwd_data [NUM_FWD];
    logic [NUM_FWD-1:0] w_hit_a;
    logic [NUM_FWD-1:0] w_hit_b;
    logic [XLEN-1:0]    w_fwd_a;
    logic [XLEN-1:0]    w_fwd_b;
    logic [XLEN-1:0]    w_src_a;
    logic [XLEN-1:0]    w_src_b;
    logic               w_ready_in;
    logic               w_capture;

    logic               r_valid_out;
    logic [XLEN-1:0]    r_src_a;
    logic [XLEN-1:0]    r_src_b;
    logic [XLEN-1:0]    r_write_data;

    // x0 is hardwired, so a producer targeting it must never override RD.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FWD; gi++) begin : g_fwd
            assign w_fwd_rd[gi]   = bus.fwd_rd[gi*REG_AW +: REG_AW];
            assign w_fwd_data[gi] = bus.fwd_data[gi*XLEN +: XLEN];
            assign w_hit_a[gi]    = bus.fwd_we[gi] && (w_fwd_rd[gi] == bus.Rs1D)
                                    && (bus.Rs1D != '0);
            assign w_hit_b[gi]    = bus.fwd_we[gi] && (w_fwd_rd[gi] == bus.Rs2D)
                                    && (bus.Rs2D != '0);
        end
    endgenerate

    // Descending scan so the youngest (lowest index) match is applied last.
    always_comb begin
        w_fwd_a = bus.RD1D;
        w_fwd_b = bus.RD2D;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (w_hit_a[i]) begin
                w_fwd_a = w_fwd_data[i];
            end
            if (w_hit_b[i]) begin
                w_fwd_b = w_fwd_data[i];
            end
        end
    end

    assign w_src_a    = bus.ALUSrcAD ? bus.PCD     : w_fwd_a;
    assign w_src_b    = bus.ALUSrcD  ? bus.ImmExtD : w_fwd_b;
    assign w_ready_in = !r_valid_out || bus.ready_out;
    assign w_capture  = bus.valid_in && w_ready_in;

    // Flush beats everything; an open slot either takes new data or drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_out  <= 1'b0;
            r_src_a      <= '0;
            r_src_b      <= '0;
            r_write_data <= '0;
        end else if (bus.flush) begin
            r_valid_out  <= 1'b0;
        end else if (w_ready_in) begin
            r_valid_out  <= bus.valid_in;
            if (w_capture) begin
                r_src_a      <= w_src_a;
                r_src_b      <= w_src_b;
                r_write_data <= w_fwd_b;
            end
        end
    end

    assign bus.ready_in   = w_ready_in;
    assign bus.valid_out  = r_valid_out;
    assign bus.SrcAE      = r_src_a;
    assign bus.SrcBE      = r_src_b;
    assign bus.WriteDataE = r_write_data;

`ifdef EXE_STALL_CNT_EN
    logic        w_stall_evt;
    logic [31:0] r_stall_cnt;

    assign w_stall_evt = (r_valid_out && !bus.ready_out) || (bus.valid_in && !w_ready_in);

    // Saturating; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed + random bench for ex_operand_stage with a capture/transfer scoreboard.
module tb_ex_operand_stage;
    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;
    localparam int REG_AW  = 5;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] wd;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    exp_t        sb_q[$];
    bit          m_valid;
    logic [31:0] m_stall;
    logic [31:0] stall_base;

    ex_operand_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) ifc ();

`ifdef EXE_STALL_CNT_EN
    logic [31:0] stall_cnt;
    ex_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc), .stall_cnt(stall_cnt));
`else
    ex_operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_AW(REG_AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Ascending search with early exit: first (youngest) matching source wins.
    function automatic logic [XLEN-1:0] fwd_exp(input logic [REG_AW-1:0] rs, input logic [XLEN-1:0] rd);
        logic [REG_AW-1:0] frd;
        if (rs == 0) return rd;
        for (int i = 0; i < NUM_FWD; i++) begin
            frd = ifc.fwd_rd[i*REG_AW +: REG_AW];
            if (ifc.fwd_we[i] && frd == rs) return ifc.fwd_data[i*XLEN +: XLEN];
        end
        return rd;
    endfunction

    task automatic set_fwd(input int idx, input bit we, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
        ifc.fwd_we[idx]                    = we;
        ifc.fwd_rd[idx*REG_AW +: REG_AW]   = rd;
        ifc.fwd_data[idx*XLEN +: XLEN]     = data;
    endtask

    task automatic idle_inputs();
        ifc.valid_in = 0; ifc.RD1D = '0; ifc.RD2D = '0; ifc.ImmExtD = '0; ifc.PCD = '0;
        ifc.Rs1D = '0; ifc.Rs2D = '0; ifc.ALUSrcD = 0; ifc.ALUSrcAD = 0;
        ifc.fwd_we = '0; ifc.fwd_rd = '0; ifc.fwd_data = '0; ifc.flush = 0; ifc.ready_out = 1;
    endtask

    task automatic model_reset();
        m_valid = 0;
        sb_q.delete();
        m_stall = 0;
    endtask

    // One clock: check ready_in, advance the model, then check outputs at negedge.
    task automatic tick(input string tag);
        bit   mr;
        exp_t e;
        #1;
        mr = !m_valid || ifc.ready_out;
        check({tag, ".ready_in"}, {31'b0, ifc.ready_in}, {31'b0, mr});
        if ((m_valid && !ifc.ready_out) || (ifc.valid_in && !mr)) m_stall = m_stall + 1;
        if (ifc.flush) begin
            m_valid = 0;
            sb_q.delete();
        end else if (mr) begin
            if (m_valid) void'(sb_q.pop_front());
            m_valid = 0;
            if (ifc.valid_in) begin
                e.a  = ifc.ALUSrcAD ? ifc.PCD : fwd_exp(ifc.Rs1D, ifc.RD1D);
                e.b  = ifc.ALUSrcD ? ifc.ImmExtD : fwd_exp(ifc.Rs2D, ifc.RD2D);
                e.wd = fwd_exp(ifc.Rs2D, ifc.RD2D);
                sb_q.push_back(e);
                m_valid = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, ".valid_out"}, {31'b0, ifc.valid_out}, {31'b0, m_valid});
        if (m_valid && sb_q.size() > 0) begin
            check({tag, ".SrcAE"}, ifc.SrcAE, sb_q[0].a);
            check({tag, ".SrcBE"}, ifc.SrcBE, sb_q[0].b);
            check({tag, ".WriteDataE"}, ifc.WriteDataE, sb_q[0].wd);
        end
`ifdef EXE_STALL_CNT_EN
        check({tag, ".stall_cnt"}, stall_cnt, m_stall);
`endif
        $display("[TB] %0t %s vin=%0b rdy_out=%0b flush=%0b vout=%0b A=%h B=%h WD=%h",
                 $time, tag, ifc.valid_in, ifc.ready_out, ifc.flush, ifc.valid_out,
                 ifc.SrcAE, ifc.SrcBE, ifc.WriteDataE);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        stall_base = 0;
        rst_n = 0;
        idle_inputs();
        model_reset();

        // Reset state.
        #1;
        check("rst.valid_out", {31'b0, ifc.valid_out}, 32'd0);
        check("rst.SrcAE", ifc.SrcAE, '0);
        check("rst.SrcBE", ifc.SrcBE, '0);
        check("rst.WriteDataE", ifc.WriteDataE, '0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // No-hazard pass-through with immediate on B.
        ifc.valid_in = 1; ifc.RD1D = 5; ifc.RD2D = 7; ifc.ImmExtD = 32'h10; ifc.ALUSrcD = 1;
        ifc.Rs1D = 1; ifc.Rs2D = 2;
        tick("pass");
        check("pass.A5", ifc.SrcAE, 32'd5);
        check("pass.B10", ifc.SrcBE, 32'h10);
        check("pass.WD7", ifc.WriteDataE, 32'd7);

        // Both sources hit rs1: youngest wins.
        ifc.ALUSrcD = 0; ifc.Rs1D = 3; ifc.RD1D = 32'h11;
        set_fwd(0, 1, 3, 32'hAA); set_fwd(1, 1, 3, 32'hBB);
        tick("prio");
        check("prio.AA", ifc.SrcAE, 32'hAA);
        set_fwd(0, 0, 3, 32'hAA);
        tick("prio1");
        check("prio1.BB", ifc.SrcAE, 32'hBB);

        // rs2 forwarded into B and store data; store data forwarded even with ALUSrc.
        ifc.Rs2D = 4; ifc.RD2D = 32'h44; set_fwd(1, 1, 4, 32'hC0DE); set_fwd(0, 0, 0, 0);
        tick("fwdB");
        check("fwdB.B", ifc.SrcBE, 32'hC0DE);
        ifc.ALUSrcD = 1; ifc.ImmExtD = 32'h7FF;
        tick("fwdB_imm");
        check("fwdB_imm.WD", ifc.WriteDataE, 32'hC0DE);

        // x0 guard and PC on A.
        ifc.ALUSrcD = 0; ifc.Rs2D = 0; ifc.RD2D = 0; set_fwd(0, 1, 0, 32'h55); set_fwd(1, 0, 0, 0);
        ifc.ALUSrcAD = 1; ifc.PCD = 32'h100;
        tick("x0");
        check("x0.B", ifc.SrcBE, 32'h0);
        check("x0.WD", ifc.WriteDataE, 32'h0);
        check("x0.PC", ifc.SrcAE, 32'h100);

        // Backpressure: A captured, B waits three stalled cycles, then B delivered.
        idle_inputs();
        ifc.valid_in = 1; ifc.RD1D = 32'hA1; ifc.RD2D = 32'hA2; ifc.Rs1D = 6; ifc.Rs2D = 7;
        tick("bp.capA");
        stall_base = m_stall;
        ifc.ready_out = 0; ifc.RD1D = 32'hB1; ifc.RD2D = 32'hB2;
        for (int i = 0; i < 3; i++) begin
            tick("bp.hold");
            check("bp.holdA", ifc.SrcAE, 32'hA1);
        end
`ifdef EXE_STALL_CNT_EN
        check("bp.stall3", stall_cnt - stall_base, 32'd3);
`endif
        ifc.ready_out = 1;
        tick("bp.deliver");
        check("bp.B", ifc.SrcAE, 32'hB1);
        ifc.valid_in = 0;
        tick("bp.drain");

        // Flush coincident with capture.
        ifc.valid_in = 1; ifc.flush = 1;
        tick("flush.cap");
        ifc.flush = 0; ifc.valid_in = 0;

        // Flush of a held stalled entry.
        ifc.valid_in = 1; ifc.RD1D = 32'hC1;
        tick("flush.capC");
        ifc.valid_in = 0; ifc.ready_out = 0;
        tick("flush.holdC");
        ifc.flush = 1;
        tick("flush.drop");
        ifc.flush = 0;
        tick("flush.after");

        // Asynchronous reset while holding a valid entry.
        ifc.ready_out = 1; ifc.valid_in = 1; ifc.RD1D = 32'hD1; ifc.RD2D = 32'hD2;
        tick("arst.capD");
        ifc.valid_in = 0; ifc.ready_out = 0;
        #2 rst_n = 0;
        #1;
        check("arst.valid_out", {31'b0, ifc.valid_out}, 32'd0);
        check("arst.SrcAE", ifc.SrcAE, '0);
        check("arst.SrcBE", ifc.SrcBE, '0);
        check("arst.WriteDataE", ifc.WriteDataE, '0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        ifc.ready_out = 1;

        // Random traffic through the scoreboard.
        for (int n = 0; n < 80; n++) begin
            ifc.valid_in  = ($urandom_range(0, 3) != 0);
            ifc.ready_out = ($urandom_range(0, 2) != 0);
            ifc.flush     = ($urandom_range(0, 9) == 0);
            ifc.RD1D = $urandom; ifc.RD2D = $urandom; ifc.ImmExtD = $urandom; ifc.PCD = $urandom;
            ifc.Rs1D = REG_AW'($urandom_range(0, 3)); ifc.Rs2D = REG_AW'($urandom_range(0, 3));
            ifc.ALUSrcD = 1'($urandom); ifc.ALUSrcAD = 1'($urandom);
            for (int k = 0; k < NUM_FWD; k++)
                set_fwd(k, 1'($urandom), REG_AW'($urandom_range(0, 3)), $urandom);
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
